pipe_ctrl: RTL and testbench

Pipeline sequencing controller between the execute stage, the fetch bus, the interrupt source and the `pc` / `if_id` / `id_ex` registers. It merges redirect and stall requests into a single jump/hold command for `pc` and per-stage flush/stall controls. It also runs the interrupt-entry handshake and a saturating stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_irq_fsm.sv | 66 ++++++
 rtl/pipe_ctrl.sv | 95 +++++++++
 tb/tb_pipe_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and encodings for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   localparam int unsigned InstAddrBus = 32;
   typedef logic [InstAddrBus-1:0] inst_addr_t;

   localparam logic ResetEnable = 1'b1;
   localparam logic JumpEnable  = 1'b1;
   localparam logic Hold_PC     = 1'b1;

   localparam logic [1:0] IrqIdle = 2'd0;
   localparam logic [1:0] IrqPend = 2'd1;
   localparam logic [1:0] IrqDone = 2'd2;

   localparam logic [31:0] StallCntMax = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl_irq_fsm.sv
// Interrupt-entry handshake: enable latch, request state machine, epc capture and take decode.
module pipe_ctrl_irq_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter logic IRQ_EN_RESET = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_reset,
   input  logic       irq_en_set_i,
   input  logic       irq_en_clr_i,
   input  logic       irq_req_i,
   input  logic       id_valid_i,
   input  inst_addr_t id_pc_i,
   input  logic       pipe_busy_i,
   output logic       take_o,
   output inst_addr_t irq_epc_o
);

   logic [1:0] state_q, state_d;
   logic       irq_en_q, irq_en_d;
   inst_addr_t epc_q;

   // Take needs a real instruction in id so epc names a resumable address.
   assign take_o = (i_reset != ResetEnable) && irq_en_q && irq_req_i && !pipe_busy_i &&
                   id_valid_i && ((state_q == IrqIdle) || (state_q == IrqPend));

   always_comb begin
      irq_en_d = irq_en_q;
      if (irq_en_set_i) irq_en_d = 1'b1;
      if (irq_en_clr_i) irq_en_d = 1'b0;
      if (take_o)       irq_en_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IrqIdle: begin
            if (take_o)         state_d = IrqDone;
            else if (irq_req_i) state_d = IrqPend;
         end
         IrqPend: begin
            if (take_o)          state_d = IrqDone;
            else if (!irq_req_i) state_d = IrqIdle;
         end
         IrqDone: begin
            if (!irq_req_i) state_d = IrqIdle;
         end
         default: state_d = IrqIdle;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_reset == ResetEnable) begin
         state_q  <= IrqIdle;
         irq_en_q <= IRQ_EN_RESET;
         epc_q    <= '0;
      end else begin
         state_q  <= state_d;
         irq_en_q <= irq_en_d;
         if (take_o) epc_q <= id_pc_i;
      end
   end

   assign irq_epc_o = epc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges redirects, interrupts and holds into pc and
// pipeline-register commands, and counts held cycles.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic IRQ_EN_RESET = 1'b0
) (
   input  logic        i_Clk,
   input  logic        i_reset,
   input  logic        i_ex_jump_flag,
   input  logic [31:0] i_ex_jump_addr,
   input  logic        i_ex_hold_req,
   input  logic        i_bus_hold_req,
   input  logic        i_id_valid,
   input  logic [31:0] i_id_pc,
   input  logic        i_irq_en_set,
   input  logic        i_irq_en_clr,
   input  logic        i_irq_req,
   input  logic [31:0] i_irq_vector,
   output logic        o_irq_ack,
   output logic [31:0] o_irq_epc,
   output logic        o_hold_flag,
   output logic        o_jump_flag,
   output logic [31:0] o_jump_addr,
   output logic        o_flush_if_id,
   output logic        o_flush_id_ex,
   output logic        o_stall_if_id,
   output logic        o_stall_id_ex,
   output logic [31:0] o_stall_cnt
);

   logic        irq_take;
   logic        pipe_busy;
   logic [31:0] stall_cnt_q;

   assign pipe_busy = i_ex_jump_flag | i_ex_hold_req | i_bus_hold_req;

   pipe_ctrl_irq_fsm #(
      .IRQ_EN_RESET (IRQ_EN_RESET)
   ) u_irq_fsm (
      .i_Clk        (i_Clk),
      .i_reset      (i_reset),
      .irq_en_set_i (i_irq_en_set),
      .irq_en_clr_i (i_irq_en_clr),
      .irq_req_i    (i_irq_req),
      .id_valid_i   (i_id_valid),
      .id_pc_i      (i_id_pc),
      .pipe_busy_i  (pipe_busy),
      .take_o       (irq_take),
      .irq_epc_o    (o_irq_epc)
   );

   always_comb begin
      o_hold_flag   = 1'b0;
      o_jump_flag   = 1'b0;
      o_jump_addr   = '0;
      o_irq_ack     = 1'b0;
      o_flush_if_id = 1'b0;
      o_flush_id_ex = 1'b0;
      o_stall_if_id = 1'b0;
      o_stall_id_ex = 1'b0;
      if (i_reset != ResetEnable) begin
         // pc sees the raw hold even on a redirect; the jump dominates it there.
         o_hold_flag = (i_ex_hold_req | i_bus_hold_req) ? Hold_PC : 1'b0;
         if (i_ex_jump_flag) begin
            o_jump_flag   = JumpEnable;
            o_jump_addr   = i_ex_jump_addr;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
         end else if (irq_take) begin
            o_jump_flag   = JumpEnable;
            o_jump_addr   = i_irq_vector;
            o_irq_ack     = 1'b1;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
         end else if (i_ex_hold_req) begin
            o_stall_if_id = 1'b1;
            o_stall_id_ex = 1'b1;
         end else if (i_bus_hold_req) begin
            o_flush_if_id = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_reset == ResetEnable) begin
         stall_cnt_q <= '0;
      end else if (o_hold_flag && (stall_cnt_q != StallCntMax)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle model comparison plus directed literal checks.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   logic        i_Clk = 1'b0;
   logic        i_reset;
   logic        i_ex_jump_flag;
   logic [31:0] i_ex_jump_addr;
   logic        i_ex_hold_req;
   logic        i_bus_hold_req;
   logic        i_id_valid;
   logic [31:0] i_id_pc;
   logic        i_irq_en_set;
   logic        i_irq_en_clr;
   logic        i_irq_req;
   logic [31:0] i_irq_vector;
   logic        o_irq_ack;
   logic [31:0] o_irq_epc;
   logic        o_hold_flag;
   logic        o_jump_flag;
   logic [31:0] o_jump_addr;
   logic        o_flush_if_id;
   logic        o_flush_id_ex;
   logic        o_stall_if_id;
   logic        o_stall_id_ex;
   logic [31:0] o_stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 i_Clk = ~i_Clk;

   pipe_ctrl dut (
      .i_Clk          (i_Clk),
      .i_reset        (i_reset),
      .i_ex_jump_flag (i_ex_jump_flag),
      .i_ex_jump_addr (i_ex_jump_addr),
      .i_ex_hold_req  (i_ex_hold_req),
      .i_bus_hold_req (i_bus_hold_req),
      .i_id_valid     (i_id_valid),
      .i_id_pc        (i_id_pc),
      .i_irq_en_set   (i_irq_en_set),
      .i_irq_en_clr   (i_irq_en_clr),
      .i_irq_req      (i_irq_req),
      .i_irq_vector   (i_irq_vector),
      .o_irq_ack      (o_irq_ack),
      .o_irq_epc      (o_irq_epc),
      .o_hold_flag    (o_hold_flag),
      .o_jump_flag    (o_jump_flag),
      .o_jump_addr    (o_jump_addr),
      .o_flush_if_id  (o_flush_if_id),
      .o_flush_id_ex  (o_flush_id_ex),
      .o_stall_if_id  (o_stall_if_id),
      .o_stall_id_ex  (o_stall_id_ex),
      .o_stall_cnt    (o_stall_cnt)
   );

   task automatic chk1(input string name, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%b required=%b at %0t", name, act, want, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
      end
   endtask

   // Model: interrupt taken when enabled, requested, pipeline quiet, id valid, and no
   // earlier ack still awaiting a low request.
   logic        m_valid = 1'b0;
   logic        m_en;
   logic        m_lock;
   logic [31:0] m_epc;
   logic [31:0] m_cnt;
   logic        e_hold, e_take, e_jump, e_fif, e_fide, e_sif, e_side;
   logic [31:0] e_addr;

   always @(negedge i_Clk) begin
      if (m_valid) begin
         e_hold = 0; e_take = 0; e_jump = 0; e_addr = 0;
         e_fif = 0; e_fide = 0; e_sif = 0; e_side = 0;
         if (!i_reset) begin
            e_hold = i_ex_hold_req || i_bus_hold_req;
            e_take = m_en && i_irq_req && !m_lock && i_id_valid && !i_ex_jump_flag && !e_hold;
            e_jump = i_ex_jump_flag || e_take;
            e_addr = i_ex_jump_flag ? i_ex_jump_addr : (e_take ? i_irq_vector : 32'd0);
            e_fide = e_jump;
            e_fif  = e_jump || (!i_ex_hold_req && i_bus_hold_req);
            e_sif  = !e_jump && i_ex_hold_req;
            e_side = e_sif;
         end
         chk1("m_hold", o_hold_flag, e_hold);
         chk1("m_ack", o_irq_ack, e_take);
         chk1("m_jump", o_jump_flag, e_jump);
         chk32("m_addr", o_jump_addr, e_addr);
         chk1("m_flush_if_id", o_flush_if_id, e_fif);
         chk1("m_flush_id_ex", o_flush_id_ex, e_fide);
         chk1("m_stall_if_id", o_stall_if_id, e_sif);
         chk1("m_stall_id_ex", o_stall_id_ex, e_side);
         chk32("m_epc", o_irq_epc, m_epc);
         chk32("m_cnt", o_stall_cnt, m_cnt);
      end
      if (i_reset) begin
         m_en = 1'b0; m_lock = 1'b0; m_epc = 0; m_cnt = 0; m_valid = 1'b1;
      end else if (m_valid) begin
         if (e_hold && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (e_take) m_epc = i_id_pc;
         if (i_irq_en_set) m_en = 1'b1;
         if (i_irq_en_clr || e_take) m_en = 1'b0;
         if (e_take) m_lock = 1'b1;
         else if (!i_irq_req) m_lock = 1'b0;
      end
   end

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   initial begin
      i_reset = 1; i_ex_jump_flag = 1; i_ex_jump_addr = 32'h0000_0100; i_ex_hold_req = 0;
      i_bus_hold_req = 0; i_id_valid = 0; i_id_pc = 0; i_irq_en_set = 0; i_irq_en_clr = 0;
      i_irq_req = 0; i_irq_vector = 0;
      tick(); tick();
      @(negedge i_Clk);
      chk1("rst_jump_forced", o_jump_flag, 1'b0);
      chk1("rst_flush_forced", o_flush_if_id, 1'b0);
      tick();
      i_reset = 0; i_ex_jump_flag = 0;
      repeat (5) tick();
      @(negedge i_Clk);
      chk32("idle_cnt", o_stall_cnt, 32'd0);
      chk1("idle_hold", o_hold_flag, 1'b0);
      chk1("idle_ack", o_irq_ack, 1'b0);
      tick();

      // Jump beats a concurrent ex hold
      i_ex_jump_flag = 1; i_ex_hold_req = 1;
      @(negedge i_Clk);
      chk1("jmp_flag", o_jump_flag, 1'b1);
      chk32("jmp_addr", o_jump_addr, 32'h0000_0100);
      chk1("jmp_flush_if_id", o_flush_if_id, 1'b1);
      chk1("jmp_flush_id_ex", o_flush_id_ex, 1'b1);
      chk1("jmp_stall_if_id", o_stall_if_id, 1'b0);
      chk1("jmp_stall_id_ex", o_stall_id_ex, 1'b0);
      tick();
      i_ex_jump_flag = 0; i_ex_hold_req = 0; i_reset = 1;
      tick();
      i_reset = 0;

      for (int i = 0; i < 3; i++) begin
         i_bus_hold_req = 1;
         @(negedge i_Clk);
         chk1("bus_hold", o_hold_flag, 1'b1);
         chk1("bus_flush_if_id", o_flush_if_id, 1'b1);
         chk1("bus_stall_id_ex", o_stall_id_ex, 1'b0);
         tick();
      end
      i_bus_hold_req = 0;
      @(negedge i_Clk);
      chk32("bus_cnt", o_stall_cnt, 32'd3);
      tick();

      // Interrupt held off by ex hold for two cycles, taken on the third
      i_irq_en_set = 1;
      tick();
      i_irq_en_set = 0; i_irq_req = 1; i_irq_vector = 32'h0000_0800;
      i_id_pc = 32'h0000_0040; i_id_valid = 1; i_ex_hold_req = 1;
      @(negedge i_Clk);
      chk1("irq_c1_ack", o_irq_ack, 1'b0);
      tick();
      @(negedge i_Clk);
      chk32("irq_pend", {30'd0, dut.u_irq_fsm.state_q}, {30'd0, IrqPend});
      chk1("irq_c2_ack", o_irq_ack, 1'b0);
      tick();
      i_ex_hold_req = 0;
      @(negedge i_Clk);
      chk1("irq_c3_ack", o_irq_ack, 1'b1);
      chk32("irq_c3_addr", o_jump_addr, 32'h0000_0800);
      tick();
      @(negedge i_Clk);
      chk32("irq_epc", o_irq_epc, 32'h0000_0040);
      chk1("irq_en_cleared", dut.u_irq_fsm.irq_en_q, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_Clk);
         chk1("irq_no_reack", o_irq_ack, 1'b0);
         tick();
      end
      i_irq_req = 0; i_irq_en_set = 1;
      tick();
      i_irq_en_set = 0; i_irq_req = 1;
      @(negedge i_Clk);
      chk1("irq_reack", o_irq_ack, 1'b1);
      tick();

      i_irq_req = 0; i_irq_en_set = 1; i_irq_en_clr = 1;
      tick();
      i_irq_en_set = 0; i_irq_en_clr = 0;
      @(negedge i_Clk);
      chk1("en_set_clr", dut.u_irq_fsm.irq_en_q, 1'b0);
      tick();

      // Jump and open window together: jump wins, interrupt retried next cycle
      i_irq_en_set = 1;
      tick();
      i_irq_en_set = 0; i_irq_req = 1; i_ex_jump_flag = 1; i_ex_jump_addr = 32'h0000_0200;
      @(negedge i_Clk);
      chk32("race_addr", o_jump_addr, 32'h0000_0200);
      chk1("race_ack", o_irq_ack, 1'b0);
      tick();
      i_ex_jump_flag = 0;
      @(negedge i_Clk);
      chk1("retry_ack", o_irq_ack, 1'b1);
      chk32("retry_addr", o_jump_addr, 32'h0000_0800);
      tick();

      // Reset while pending
      i_irq_req = 0; i_irq_en_set = 1;
      tick();
      i_irq_en_set = 0; i_irq_req = 1; i_ex_hold_req = 1;
      tick();
      @(negedge i_Clk);
      chk32("pend_before_rst", {30'd0, dut.u_irq_fsm.state_q}, {30'd0, IrqPend});
      tick();
      i_reset = 1; i_ex_hold_req = 0;
      @(negedge i_Clk);
      chk1("rst_pend_ack", o_irq_ack, 1'b0);
      tick();
      i_reset = 0; i_irq_req = 0;
      @(negedge i_Clk);
      chk32("rst_idle", {30'd0, dut.u_irq_fsm.state_q}, {30'd0, IrqIdle});
      chk32("rst_epc", o_irq_epc, 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
